// File: rtl/sync_to_count_lock.sv
// Column/row counter regenerator that aligns to the sync leading edges and
// supervises every subsequent edge against the expected position.
module sync_to_count_lock #(
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int H_SYNC_COL      = 656,
    parameter int V_SYNC_ROW      = 490,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int COUNT_WIDTH     = 10,
    parameter int MAX_MISSES      = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count,
    output logic                   o_Locked,
    output logic                   o_Sync_Err,
    output logic                   o_Frame_Start
);

    localparam int MISS_W = $clog2(MAX_MISSES + 1);
    localparam logic ACT_LOW = (SYNC_ACTIVE_LOW != 0);
    localparam logic [COUNT_WIDTH-1:0] LAST_COL = COUNT_WIDTH'(TOTAL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_ROW = COUNT_WIDTH'(TOTAL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] SYNC_COL = COUNT_WIDTH'(H_SYNC_COL);
    localparam logic [COUNT_WIDTH-1:0] SYNC_ROW = COUNT_WIDTH'(V_SYNC_ROW);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MAX_MISSES - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t                   state, state_n;
    logic [MISS_W-1:0]        miss, miss_n;
    logic [COUNT_WIDTH-1:0]   col_n, row_n, col_d, row_d;
    logic                     h_edge, v_edge, h_bad, v_bad;
    logic                     err_n, fs_n;

    // An edge is the input going active while the delayed copy is still inactive.
    assign h_edge = (i_HSync ^ ACT_LOW) & ~(o_HSync ^ ACT_LOW);
    assign v_edge = (i_VSync ^ ACT_LOW) & ~(o_VSync ^ ACT_LOW);

    assign o_Locked = (state == LOCKED);

    always_comb begin
        col_n   = (o_Col_Count == LAST_COL) ? '0 : o_Col_Count + 1'b1;
        row_n   = o_Row_Count;
        if (o_Col_Count == LAST_COL)
            row_n = (o_Row_Count == LAST_ROW) ? '0 : o_Row_Count + 1'b1;

        h_bad   = h_edge && (col_n != SYNC_COL);
        v_bad   = v_edge && !((col_n == SYNC_COL) && (row_n == SYNC_ROW));

        state_n = state;
        miss_n  = miss;
        col_d   = col_n;
        row_d   = row_n;
        err_n   = 1'b0;

        case (state)
            SEARCH: begin
                if (v_edge) begin
                    col_d   = SYNC_COL;
                    row_d   = SYNC_ROW;
                    miss_n  = '0;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                // Simultaneous bad H and V edges are a single miss.
                if (h_bad || v_bad) begin
                    err_n = 1'b1;
                    if (miss >= MISS_LAST) begin
                        miss_n  = MISS_LIMIT;
                        state_n = SEARCH;
                    end else begin
                        miss_n = miss + 1'b1;
                    end
                end else if (h_edge || v_edge) begin
                    miss_n = '0;
                end
            end
            default: state_n = SEARCH;
        endcase

        fs_n = (state_n == LOCKED) && (col_d == '0) && (row_d == '0);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state         <= SEARCH;
            miss          <= '0;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_HSync       <= ACT_LOW;
            o_VSync       <= ACT_LOW;
            o_Sync_Err    <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            state         <= state_n;
            miss          <= miss_n;
            o_Col_Count   <= col_d;
            o_Row_Count   <= row_d;
            o_HSync       <= i_HSync;
            o_VSync       <= i_VSync;
            o_Sync_Err    <= err_n;
            o_Frame_Start <= fs_n;
        end
    end

endmodule
